bp_dram_burst_arbiter: RTL and testbench

// - Shares one DRAM channel (addr/cmd, write-data, read-data) among num_req_p burst requesters.
// - Each requester posts one burst command: base channel addr, R/W, beat count.
//   The arbiter expands it into per-word DRAM commands and steers write data out and read data back.
// - Sits between the per-core burst-to-DRAM converters and the DRAM controller.

---
 rtl/bp_dram_burst_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_bp_dram_burst_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_dram_burst_arbiter.sv
// Round-robin arbiter that expands per-requester burst commands into per-word DRAM commands.
// Define BP_DRAM_ARB_STALL_CNT_EN to add stall_cnt_o, a saturating count of back-pressured cycles.
module bp_dram_burst_arbiter #(
    parameter int num_req_p            = 2,
    parameter int channel_addr_width_p = 28,
    parameter int data_width_p         = 64,
    parameter int max_burst_len_p      = 8,
    parameter int rd_track_els_p       = 16,
    localparam int byte_w              = data_width_p / 8,
    localparam int lg_bl               = $clog2(max_burst_len_p),
    localparam int id_w                = $clog2(num_req_p),
    localparam int trk_w               = $clog2(rd_track_els_p)
) (
    input  logic                                            clk_i,
    input  logic                                            reset_n_i,
    input  logic [num_req_p-1:0]                            req_v_i,
    input  logic [num_req_p-1:0]                            req_w_i,
    input  logic [num_req_p-1:0][channel_addr_width_p-1:0]  req_addr_i,
    input  logic [num_req_p-1:0][lg_bl-1:0]                 req_len_i,
    output logic [num_req_p-1:0]                            req_yumi_o,
    input  logic [num_req_p-1:0][data_width_p-1:0]          req_data_i,
    input  logic [num_req_p-1:0][byte_w-1:0]                req_mask_i,
    input  logic [num_req_p-1:0]                            req_data_v_i,
    output logic [num_req_p-1:0]                            req_data_yumi_o,
    output logic [data_width_p-1:0]                         resp_data_o,
    output logic [num_req_p-1:0]                            resp_v_o,
    input  logic [num_req_p-1:0]                            resp_ready_i,
    output logic [channel_addr_width_p-1:0]                 dram_ch_addr_o,
    output logic                                            dram_write_not_read_o,
    output logic                                            dram_v_o,
    input  logic                                            dram_yumi_i,
    output logic [data_width_p-1:0]                         dram_data_o,
    output logic [byte_w-1:0]                               dram_mask_o,
    output logic                                            dram_data_v_o,
    input  logic                                            dram_data_yumi_i,
    input  logic [data_width_p-1:0]                         dram_data_i,
    input  logic                                            dram_data_v_i,
`ifdef BP_DRAM_ARB_STALL_CNT_EN
    output logic [31:0]                                     stall_cnt_o,
`endif
    output logic                                            dram_data_ready_o
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_e;
    typedef logic [channel_addr_width_p-1:0] addr_t;

    state_e            state_r, state_n;
    logic [id_w-1:0]   rr_r, gnt_r, sel, arb_idx;
    logic [id_w:0]     arb_sum;
    logic              sel_v, grant, burst_end;
    addr_t             base_r;
    logic [lg_bl-1:0]  len_r;
    logic [lg_bl:0]    len_x, cnt_a_r, cnt_d_r;
    logic              cmd_fire, data_fire, a_done, d_done, a_fin, d_fin;

    logic [id_w-1:0]   trk_mem [rd_track_els_p];
    logic [trk_w-1:0]  trk_wp_r, trk_rp_r;
    logic [trk_w:0]    trk_cnt_r, trk_free;
    logic              trk_push, trk_pop, trk_empty;
    logic [id_w-1:0]   owner;

    assign len_x     = {1'b0, len_r};
    assign a_done    = cnt_a_r > len_x;
    assign d_done    = cnt_d_r > len_x;
    assign cmd_fire  = dram_v_o & dram_yumi_i;
    assign data_fire = dram_data_v_o & dram_data_yumi_i;
    assign a_fin     = a_done | (cmd_fire & (cnt_a_r == len_x));
    assign d_fin     = d_done | (data_fire & (cnt_d_r == len_x));
    assign trk_free  = (trk_w+1)'(rd_track_els_p) - trk_cnt_r;

    // Round-robin search from rr_r; a read only qualifies if every beat fits in the tracker.
    always_comb begin
        sel     = '0;
        sel_v   = 1'b0;
        arb_sum = '0;
        arb_idx = '0;
        for (int k = 0; k < num_req_p; k++) begin
            arb_sum = {1'b0, rr_r} + (id_w+1)'(k);
            if (arb_sum >= (id_w+1)'(num_req_p))
                arb_sum = arb_sum - (id_w+1)'(num_req_p);
            arb_idx = arb_sum[id_w-1:0];
            if (!sel_v && req_v_i[arb_idx] &&
                (req_w_i[arb_idx] || (32'(req_len_i[arb_idx]) < 32'(trk_free)))) begin
                sel_v = 1'b1;
                sel   = arb_idx;
            end
        end
    end

    // Gated by reset so the combinational grant stays low while held in reset.
    assign grant     = (state_r == IDLE) & sel_v & reset_n_i;
    assign burst_end = (state_r != IDLE) & (state_n == IDLE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= IDLE;
        else            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    if (grant) state_n = req_w_i[sel] ? WR : RD;
            RD:      if (cmd_fire && (cnt_a_r == len_x)) state_n = IDLE;
            WR:      if (a_fin && d_fin) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        req_yumi_o            = '0;
        req_data_yumi_o       = '0;
        dram_v_o              = 1'b0;
        dram_write_not_read_o = 1'b0;
        dram_data_v_o         = 1'b0;
        if (grant) req_yumi_o[sel] = 1'b1;
        case (state_r)
            RD: dram_v_o = 1'b1;
            WR: begin
                dram_write_not_read_o  = 1'b1;
                dram_v_o               = !a_done;
                dram_data_v_o          = !d_done && req_data_v_i[gnt_r];
                req_data_yumi_o[gnt_r] = dram_data_v_o && dram_data_yumi_i;
            end
            default: ;
        endcase
    end

    assign dram_ch_addr_o = base_r + addr_t'(cnt_a_r) * addr_t'(byte_w);
    assign dram_data_o    = req_data_i[gnt_r];
    assign dram_mask_o    = req_mask_i[gnt_r];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_r    <= '0;
            gnt_r   <= '0;
            base_r  <= '0;
            len_r   <= '0;
            cnt_a_r <= '0;
            cnt_d_r <= '0;
        end else begin
            if (grant) begin
                gnt_r   <= sel;
                base_r  <= req_addr_i[sel];
                len_r   <= req_len_i[sel];
                cnt_a_r <= '0;
                cnt_d_r <= '0;
            end else begin
                if (cmd_fire)  cnt_a_r <= cnt_a_r + 1'b1;
                if (data_fire) cnt_d_r <= cnt_d_r + 1'b1;
            end
            if (burst_end)
                rr_r <= (gnt_r == id_w'(num_req_p-1)) ? '0 : gnt_r + 1'b1;
        end
    end

    // Read-owner tracker: DRAM returns in issue order, so the head names the owner.
    assign trk_push  = (state_r == RD) & cmd_fire;
    assign trk_empty = (trk_cnt_r == '0);
    assign owner     = trk_mem[trk_rp_r];
    assign trk_pop   = dram_data_v_i & dram_data_ready_o;

    always_ff @(posedge clk_i) begin
        if (trk_push) trk_mem[trk_wp_r] <= gnt_r;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            trk_wp_r  <= '0;
            trk_rp_r  <= '0;
            trk_cnt_r <= '0;
        end else begin
            if (trk_push) trk_wp_r <= trk_wp_r + 1'b1;
            if (trk_pop)  trk_rp_r <= trk_rp_r + 1'b1;
            case ({trk_push, trk_pop})
                2'b10:   trk_cnt_r <= trk_cnt_r + 1'b1;
                2'b01:   trk_cnt_r <= trk_cnt_r - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        resp_v_o = '0;
        if (dram_data_v_i && !trk_empty) resp_v_o[owner] = 1'b1;
    end

    assign dram_data_ready_o = !trk_empty && resp_ready_i[owner];
    assign resp_data_o       = dram_data_i;

`ifdef BP_DRAM_ARB_STALL_CNT_EN
    logic stall;
    assign stall = (dram_v_o && !dram_yumi_i) || (dram_data_v_o && !dram_data_yumi_i);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)                          stall_cnt_o <= '0;
        else if (stall && (stall_cnt_o != '1))   stall_cnt_o <= stall_cnt_o + 1'b1;
    end
`endif

endmodule

// File: tb/tb_bp_dram_burst_arbiter.sv
// Randomized bench for bp_dram_burst_arbiter against a transaction-level model of
// round-robin grants, burst expansion, write-data steering and in-order read return.
`timescale 1ns/1ps
module tb_bp_dram_burst_arbiter;
    localparam int N = 2, AW = 28, DW = 64, BW = 8, LGBL = 3, TRK = 16;

    logic                      clk = 1'b0, reset_n;
    logic [N-1:0]              req_v, req_w, req_yumi, req_data_v, req_data_yumi;
    logic [N-1:0][AW-1:0]      req_addr;
    logic [N-1:0][LGBL-1:0]    req_len;
    logic [N-1:0][DW-1:0]      req_data;
    logic [N-1:0][BW-1:0]      req_mask;
    logic [DW-1:0]             resp_data, dram_data_out, dram_data_in;
    logic [N-1:0]              resp_v, resp_ready;
    logic [AW-1:0]             dram_addr;
    logic                      dram_wnr, dram_v, dram_yumi, dram_data_v, dram_data_yumi;
    logic [BW-1:0]             dram_mask;
    logic                      dram_data_v_in, dram_data_ready;
`ifdef BP_DRAM_ARB_STALL_CNT_EN
    logic [31:0]               stall_cnt;
`endif

    bp_dram_burst_arbiter dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .req_v_i(req_v), .req_w_i(req_w), .req_addr_i(req_addr), .req_len_i(req_len),
        .req_yumi_o(req_yumi), .req_data_i(req_data), .req_mask_i(req_mask),
        .req_data_v_i(req_data_v), .req_data_yumi_o(req_data_yumi),
        .resp_data_o(resp_data), .resp_v_o(resp_v), .resp_ready_i(resp_ready),
        .dram_ch_addr_o(dram_addr), .dram_write_not_read_o(dram_wnr), .dram_v_o(dram_v),
        .dram_yumi_i(dram_yumi), .dram_data_o(dram_data_out), .dram_mask_o(dram_mask),
        .dram_data_v_o(dram_data_v), .dram_data_yumi_i(dram_data_yumi),
        .dram_data_i(dram_data_in), .dram_data_v_i(dram_data_v_in),
`ifdef BP_DRAM_ARB_STALL_CNT_EN
        .stall_cnt_o(stall_cnt),
`endif
        .dram_data_ready_o(dram_data_ready)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Model: one active burst (busy) described by owner, type, base, beats left to issue.
    bit            busy = 0, bw = 0;
    int            bg = 0, blen = 0, cmd_rem = 0, rr = 0;
    logic [AW-1:0] bbase = '0;
    logic [DW-1:0] wq_d[$];
    logic [BW-1:0] wq_m[$];
    int            rq_own[$];
    logic [DW-1:0] rq_dat[$];
    bit            pend[N], pend_w[N];
    logic [AW-1:0] pend_a[N];
    int            pend_l[N];
    int            p_req, p_w, p_yumi, p_dyumi, p_dv, p_ret, p_rdy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic finish_tb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req_yumi"}, req_yumi, '0);
        chk({tag, "_dram_v"}, dram_v, 0);
        chk({tag, "_dram_data_v"}, dram_data_v, 0);
        chk({tag, "_req_data_yumi"}, req_data_yumi, '0);
        chk({tag, "_resp_v"}, resp_v, '0);
        chk({tag, "_dram_data_ready"}, dram_data_ready, 0);
    endtask

    function automatic bit rnd(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    task automatic drive();
        logic [AW-1:0] a;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && rnd(p_req)) begin
                a = AW'($urandom);
                if ($urandom_range(7) == 0) a[AW-1:6] = '1;
                a[2:0]    = '0;
                pend[i]   = 1;
                pend_w[i] = rnd(p_w);
                pend_a[i] = a;
                pend_l[i] = $urandom_range(7);
            end
            req_v[i]    = pend[i];
            req_w[i]    = pend_w[i];
            req_addr[i] = pend_a[i];
            req_len[i]  = LGBL'(pend_l[i]);
            if (busy && bw && i == bg && wq_d.size() > 0) begin
                req_data_v[i] = rnd(p_dv);
                req_data[i]   = wq_d[0];
                req_mask[i]   = wq_m[0];
            end else begin
                req_data_v[i] = $urandom_range(1);
                req_data[i]   = {$urandom, $urandom};
                req_mask[i]   = BW'($urandom);
            end
            resp_ready[i] = rnd(p_rdy);
        end
        dram_yumi      = rnd(p_yumi);
        dram_data_yumi = rnd(p_dyumi);
        dram_data_v_in = rq_own.size() > 0 && rnd(p_ret);
        dram_data_in   = rq_own.size() > 0 ? rq_dat[0] : {$urandom, $urandom};
    endtask

    // Check one cycle at the negedge, advance the model to the coming posedge, then redrive.
    task automatic step();
        logic [N-1:0]  ey, edy, erv;
        logic [AW-1:0] ea;
        bit            edv, eddv, erdy;
        int            g, idx;
        @(negedge clk);
        ey = '0;
        g  = -1;
        if (!busy)
            for (int k = 0; k < N; k++) begin
                idx = (rr + k) % N;
                if (g < 0 && req_v[idx] &&
                    (req_w[idx] || int'(req_len[idx]) + 1 <= TRK - rq_own.size())) begin
                    g = idx;
                    ey[idx] = 1'b1;
                end
            end
        chk("req_yumi", req_yumi, ey);
        edv = busy && cmd_rem > 0;
        chk("dram_v", dram_v, edv);
        if (edv) begin
            ea = bbase + AW'((blen + 1 - cmd_rem) * BW);
            chk("dram_addr", dram_addr, ea);
            chk("dram_wnr", dram_wnr, bw);
        end
        eddv = busy && bw && wq_d.size() > 0 && req_data_v[bg];
        chk("dram_data_v", dram_data_v, eddv);
        if (eddv) begin
            chk("dram_data", dram_data_out, wq_d[0]);
            chk("dram_mask", dram_mask, wq_m[0]);
        end
        edy = '0;
        if (eddv && dram_data_yumi) edy[bg] = 1'b1;
        chk("req_data_yumi", req_data_yumi, edy);
        erv  = '0;
        erdy = 0;
        if (rq_own.size() > 0) begin
            erdy = resp_ready[rq_own[0]];
            if (dram_data_v_in) erv[rq_own[0]] = 1'b1;
        end
        chk("resp_v", resp_v, erv);
        chk("dram_data_ready", dram_data_ready, erdy);
        if (erv != '0) chk("resp_data", resp_data, rq_dat[0]);

        if (rq_own.size() > 0 && dram_data_v_in && erdy) begin
            void'(rq_own.pop_front());
            void'(rq_dat.pop_front());
        end
        if (g >= 0) begin
            busy    = 1;
            bg      = g;
            bw      = req_w[g];
            bbase   = req_addr[g];
            blen    = int'(req_len[g]);
            cmd_rem = blen + 1;
            pend[g] = 0;
            if (bw)
                for (int b = 0; b <= blen; b++) begin
                    wq_d.push_back({$urandom, $urandom});
                    wq_m.push_back(BW'($urandom));
                end
        end
        if (edv && dram_yumi) begin
            cmd_rem--;
            if (!bw) begin
                rq_own.push_back(bg);
                rq_dat.push_back({$urandom, $urandom});
            end
        end
        if (eddv && dram_data_yumi) begin
            void'(wq_d.pop_front());
            void'(wq_m.pop_front());
        end
        if (busy && g < 0 && cmd_rem == 0 && wq_d.size() == 0) begin
            busy = 0;
            rr   = (bg + 1) % N;
        end
        if (failures >= 50) finish_tb();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic set_p(input int rq, input int w, input int y, input int dy, input int dv,
                         input int rt, input int rd);
        p_req = rq; p_w = w; p_yumi = y; p_dyumi = dy; p_dv = dv; p_ret = rt; p_rdy = rd;
    endtask

    initial begin
        int n;
        reset_n        = 1'b0;
        req_v          = '1;
        req_w          = '0;
        req_addr       = '0;
        req_len        = '0;
        req_data       = '0;
        req_mask       = '0;
        req_data_v     = '1;
        resp_ready     = '1;
        dram_yumi      = 1'b1;
        dram_data_yumi = 1'b1;
        dram_data_in   = '0;
        dram_data_v_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");

        // Directed read len=3 at 0x100 from requester 0, returned to requester 0.
        @(posedge clk); #1;
        set_p(0, 0, 100, 100, 100, 0, 100);
        pend[0] = 1; pend_w[0] = 0; pend_a[0] = AW'(28'h100); pend_l[0] = 3;
        drive();
        reset_n = 1'b1;
        repeat (8) step();
        p_ret = 100;
        repeat (8) step();

        // Directed write len=1 whose data lags the command beats.
        pend[0] = 1; pend_w[0] = 1; pend_a[0] = AW'(28'h40); pend_l[0] = 1;
        p_dv = 0;
        repeat (5) step();
        p_dv = 100;
        repeat (6) step();

        // Both requesters always valid: round-robin alternation.
        set_p(100, 50, 100, 100, 100, 100, 100);
        repeat (80) step();

        // Reads only with return stalled: tracker fills and blocks grants.
        set_p(100, 0, 70, 100, 100, 0, 100);
        repeat (150) step();
        p_ret = 30; p_rdy = 50;
        repeat (150) step();

        // General random traffic.
        set_p(60, 50, 60, 60, 60, 60, 60);
        repeat (2500) step();

        // Reset in the middle of a long write burst.
        set_p(100, 100, 50, 50, 70, 60, 70);
        n = 0;
        while (!(busy && bw && blen >= 2 && cmd_rem < blen) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL rst_wait no mid-burst write within %0d cycles", n);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_quiet("midrst");
        busy = 0; rr = 0; cmd_rem = 0;
        wq_d.delete(); wq_m.delete(); rq_own.delete(); rq_dat.delete();
        @(posedge clk); #1;
        set_p(100, 0, 70, 100, 100, 80, 80);
        drive();
        reset_n = 1'b1;
        repeat (40) step();
        set_p(60, 50, 60, 60, 60, 60, 60);
        repeat (800) step();

        // Drain.
        set_p(0, 0, 100, 100, 100, 100, 100);
        repeat (120) step();
        finish_tb();
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog timeout t=%0t", $time);
        finish_tb();
    end

endmodule
